// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the LCD sequencing controller.
//   lcd_state_t : controller FSM states
//   INIT_ROM    : HD44780 4-bit init commands, entry 0 sent first
//   LINE1_ADDR / LINE2_ADDR : DDRAM set-address commands for each line
//   cnt_width() : width of a counter able to hold the largest cycle count
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT_SEND,
    ST_INIT_WAIT,
    ST_CLR_WAIT,
    ST_IDLE,
    ST_ADDR_SEND,
    ST_CHAR_SEND,
    ST_DRV_WAIT
  } lcd_state_t;

  localparam int INIT_LEN = 6;
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM =
    {8'h01, 8'h06, 8'h0C, 8'h28, 8'h32, 8'h33};

  localparam logic [7:0] LINE1_ADDR = 8'h80;
  localparam logic [7:0] LINE2_ADDR = 8'hC0;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// lcd_ctrl_if: host-side buffer/refresh signals plus the byte handshake to
// the nibble driver.
//   slave  : controller view (host writes in, driver commands out)
//   master : host/driver-model view
interface lcd_ctrl_if;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       refresh;
  logic       ready;
  logic       drv_start;
  logic       drv_rs;
  logic [7:0] drv_data;
  logic       drv_busy;

  modport slave (
    input  wr_en, wr_addr, wr_data, refresh, drv_busy,
    output ready, drv_start, drv_rs, drv_data
  );

  modport master (
    output wr_en, wr_addr, wr_data, refresh, drv_busy,
    input  ready, drv_start, drv_rs, drv_data
  );
endinterface

// File: rtl/lcd_char_buf.sv
// lcd_char_buf: 32 x 8 character buffer (0-15 line 1, 16-31 line 2).
//   clk, rst_n        : clock, async active-low reset (all entries -> 0x20)
//   wr_en/addr/data   : write port
//   rd_en, rd_addr    : read request; rd_data updates the next cycle and
//                       holds until the next read. A same-cycle write to the
//                       read address is not visible (old value returned).
module lcd_char_buf (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data
);
  logic [7:0] mem [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h20;
      rd_data <= 8'h00;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
    end
  end
endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780-style LCD sequencer. Waits out power-up, sends the init
// command list, then redraws the 32-character buffer on request.
//   clk, rst_n : system clock, async active-low reset
//   bus        : lcd_ctrl_if.slave (host writes/refresh/ready, driver handshake)
// Optional: define LCD_CTRL_AUTOREFRESH_EN to request a redraw every
// REFRESH_CYC cycles once init has completed.
//
// state       | meaning
// PWRUP       | power-on delay, PWRUP_CYC cycles
// INIT_SEND   | start pulse for init command init_idx
// INIT_WAIT   | wait for driver to finish an init command
// CLR_WAIT    | extra CLR_CYC cycles after clear-display
// IDLE        | ready; start redraw if a refresh is pending
// ADDR_SEND   | start pulse for a line set-address command
// CHAR_SEND   | start pulse for character char_idx
// DRV_WAIT    | wait for driver to finish a redraw transaction
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC   = 180000,
  parameter int CLR_CYC     = 19200,
  parameter int REFRESH_CYC = 1200000
) (
  input logic       clk,
  input logic       rst_n,
  lcd_ctrl_if.slave bus
);
  localparam int CNT_W = cnt_width(PWRUP_CYC, CLR_CYC, REFRESH_CYC);

  lcd_state_t       state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [2:0]       init_idx, init_idx_n;
  logic [4:0]       char_idx, char_idx_n;
  logic             pending, start_redraw, ref_tick;
  logic             wait_first, done;
  logic             rs_q, rs_n;
  logic [7:0]       cmd_q, cmd_n;
  logic             rd_en;
  logic [7:0]       rd_data;

  lcd_char_buf u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (bus.wr_en),
    .wr_addr(bus.wr_addr),
    .wr_data(bus.wr_data),
    .rd_en  (rd_en),
    .rd_addr(char_idx_n),
    .rd_data(rd_data)
  );

  // The cycle right after a start pulse ignores drv_busy.
  assign done = !wait_first && !bus.drv_busy;

  always_comb begin
    state_n      = state;
    timer_n      = timer;
    init_idx_n   = init_idx;
    char_idx_n   = char_idx;
    rs_n         = rs_q;
    cmd_n        = cmd_q;
    rd_en        = 1'b0;
    start_redraw = 1'b0;
    case (state)
      ST_PWRUP: begin
        if (timer == CNT_W'(PWRUP_CYC - 1)) begin
          state_n    = ST_INIT_SEND;
          timer_n    = '0;
          init_idx_n = 3'd0;
          rs_n       = 1'b0;
          cmd_n      = INIT_ROM[0];
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      ST_INIT_SEND: state_n = ST_INIT_WAIT;
      ST_INIT_WAIT: begin
        if (done) begin
          if (init_idx == 3'(INIT_LEN - 1)) begin
            state_n = ST_CLR_WAIT;
            timer_n = '0;
          end else begin
            state_n    = ST_INIT_SEND;
            init_idx_n = init_idx + 3'd1;
            rs_n       = 1'b0;
            cmd_n      = INIT_ROM[init_idx_n];
          end
        end
      end
      ST_CLR_WAIT: begin
        if (timer == CNT_W'(CLR_CYC - 1)) begin
          state_n = ST_IDLE;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      ST_IDLE: begin
        if (pending) begin
          start_redraw = 1'b1;
          state_n      = ST_ADDR_SEND;
          char_idx_n   = 5'd0;
          rs_n         = 1'b0;
          cmd_n        = LINE1_ADDR;
        end
      end
      ST_ADDR_SEND, ST_CHAR_SEND: state_n = ST_DRV_WAIT;
      ST_DRV_WAIT: begin
        if (done) begin
          // rs_q tells whether the finished transaction was an address
          // command (first char of the line follows) or a character.
          if (!rs_q) begin
            state_n = ST_CHAR_SEND;
            rs_n    = 1'b1;
            rd_en   = 1'b1;
          end else if (char_idx == 5'd15) begin
            state_n    = ST_ADDR_SEND;
            char_idx_n = 5'd16;
            rs_n       = 1'b0;
            cmd_n      = LINE2_ADDR;
          end else if (char_idx == 5'd31) begin
            state_n    = ST_IDLE;
            char_idx_n = 5'd0;
          end else begin
            state_n    = ST_CHAR_SEND;
            char_idx_n = char_idx + 5'd1;
            rs_n       = 1'b1;
            rd_en      = 1'b1;
          end
        end
      end
      default: state_n = ST_PWRUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_PWRUP;
      timer      <= '0;
      init_idx   <= 3'd0;
      char_idx   <= 5'd0;
      pending    <= 1'b0;
      wait_first <= 1'b0;
      rs_q       <= 1'b0;
      cmd_q      <= 8'h00;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      init_idx   <= init_idx_n;
      char_idx   <= char_idx_n;
      pending    <= bus.refresh | ref_tick | (pending & !start_redraw);
      wait_first <= (state == ST_INIT_SEND) || (state == ST_ADDR_SEND) ||
                    (state == ST_CHAR_SEND);
      rs_q       <= rs_n;
      cmd_q      <= cmd_n;
    end
  end

`ifdef LCD_CTRL_AUTOREFRESH_EN
  logic             init_done;
  logic [CNT_W-1:0] ref_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done <= 1'b0;
      ref_cnt   <= '0;
    end else begin
      if (state == ST_CLR_WAIT && state_n == ST_IDLE) init_done <= 1'b1;
      if (init_done) ref_cnt <= ref_tick ? '0 : ref_cnt + 1'b1;
    end
  end

  assign ref_tick = init_done && (ref_cnt == CNT_W'(REFRESH_CYC - 1));
`else
  assign ref_tick = 1'b0;
`endif

  // Character data comes straight from the buffer read register, which only
  // reloads on the next character read, so it holds until the next start.
  assign bus.drv_start = (state == ST_INIT_SEND) || (state == ST_ADDR_SEND) ||
                         (state == ST_CHAR_SEND);
  assign bus.drv_rs    = rs_q;
  assign bus.drv_data  = rs_q ? rd_data : cmd_q;
  assign bus.ready     = (state == ST_IDLE);
endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 SHALL have parameter PWRUP_CYC, 180000, power-on wait in clk cycles (15 ms at 12 MHz).
REQ-002 SHALL have parameter CLR_CYC, 19200, extra wait after clear-display command (1.6 ms).
REQ-003 SHALL have parameter REFRESH_CYC, 1200000, auto-refresh period in clk cycles (100 ms).
REQ-004 One clock; reset is asynchronous and active-low: clk  in  1  system clock; rst_n  in  1  async active-low reset.
REQ-005 wr_en  in  1  host buffer write strobe.
REQ-006 wr_addr  in  5  character index; 0-15 line 1, 16-31 line 2.
REQ-007 wr_data  in  8  ASCII character.
REQ-008 refresh  in  1  single-cycle request to redraw the full display.
REQ-009 ready  out  1  high when initialised and idle.
REQ-010 drv_start  out  1  single-cycle start pulse to the nibble driver.
REQ-011 drv_rs  out  1  register select to driver; 0 command, 1 data.
REQ-012 drv_data  out  8  byte to driver, valid with drv_start.
REQ-013 drv_busy  in  1  driver busy flag.

Function
REQ-014 States: PWRUP, INIT_SEND, INIT_WAIT, CLR_WAIT, IDLE, ADDR_SEND, CHAR_SEND, DRV_WAIT.
REQ-015 PWRUP counts PWRUP_CYC cycles, then enters INIT_SEND with init index 0.
REQ-016 Init sequence, rs=0, in order: 0x33, 0x32, 0x28, 0x0C, 0x06, 0x01.
REQ-017 Every driver transaction: drv_start high exactly one cycle with drv_rs/drv_data stable that cycle and held until next start; the following cycle busy is ignored; completion is the first later cycle with drv_busy=0.
REQ-018 After 0x01 completes, CLR_WAIT counts CLR_CYC cycles, then IDLE; ready rises the first cycle in IDLE.
REQ-019 In IDLE, a pending refresh starts a redraw: command 0x80, characters 0-15 (rs=1), command 0xC0, characters 16-31; total 34 transactions; return to IDLE.
REQ-020 ready SHALL be 0 in every state other than IDLE.
REQ-021 Buffer writes accepted in all states, one per cycle; unwritten locations reset to 0x20 (space).
REQ-022 Character sent is the buffer content at the cycle its read is issued; write and read to the same address in the same cycle returns the old value.
REQ-023 refresh pulses during init or a redraw SHALL be latched into one pending flag; multiple pulses coalesce into one subsequent redraw.
REQ-024 refresh coincident with redraw completion SHALL cause exactly one further redraw.
REQ-025 Character index counter 5 bits, wraps 31->0 only on redraw completion.

Reset
REQ-026 On rst_n low: state PWRUP, all counters 0, pending flag 0, ready 0, drv_start 0, drv_rs 0, drv_data 0x00, buffer all 0x20.
REQ-027 Reset asserted mid-transaction SHALL restart from PWRUP; full init sequence repeats.

Configuration
REQ-028 Macro LCD_CTRL_AUTOREFRESH_EN defined: free-running REFRESH_CYC counter in IDLE-independent operation sets the pending flag each period after init completes.
REQ-029 Macro undefined: no period counter; redraws occur only on refresh input.

Structure
REQ-030 Package lcd_pkg SHALL hold: state enumeration, init command ROM (6 x 8 bits), LINE1_ADDR 0x80, LINE2_ADDR 0xC0, INIT_LEN 6.
REQ-031 Sub-module lcd_char_buf: 32x8 buffer, one write port, one registered read port, reset to 0x20.

Verification
REQ-032 Reset release, drv_busy model 10 cycles per transaction, PWRUP_CYC=100 -> first drv_start at cycle 100 with data 0x33, then 0x32,0x28,0x0C,0x06,0x01 rs=0, ready high CLR_CYC cycles after 0x01 completes.
REQ-033 Write "HELLO" to addr 0-4, "WORLD" to 16-20, pulse refresh -> 34 starts: 0x80, H,E,L,L,O, 11x 0x20, 0xC0, W,O,R,L,D, 11x 0x20.
REQ-034 Three refresh pulses during one redraw -> exactly one additional redraw, then IDLE.
REQ-035 Write addr 5 = 0x41 while redraw at index 3 -> 0x41 sent at position 5 same redraw.
REQ-036 rst_n low during character 10 of redraw -> all outputs 0 next cycle, init sequence restarts from 0x33.
REQ-037 LCD_CTRL_AUTOREFRESH_EN defined, REFRESH_CYC=2000, no refresh input -> redraw starts every 2000 cycles after ready.
